// File: rtl/zeta_gen.sv
// Runtime twiddle-factor generator: streams zeta[k] = ROOT^brv(k) mod Q to the NTT stage banks.
// Optional macro ZETA_GEN_MONT_EN emits each zeta in the Montgomery domain (adds one CONV cycle per write).
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module zeta_gen #(
  parameter int unsigned Q         = 3329,
  parameter int unsigned ROOT      = 17,
  parameter int unsigned MONT_BITS = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               wr_valid,
  input  logic                               wr_ready,
  output logic [$clog2(`NTT_STAGE_CNT)-1:0]  wr_stage,
  output logic [`NTT_STAGE_CNT-2:0]          wr_addr,
  output logic [`DATA_WIDTH-1:0]             wr_data
);

  localparam int unsigned N  = `NTT_STAGE_CNT;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned SW = $clog2(N);
  localparam int unsigned AW = N - 1;
  localparam int unsigned PW = 2 * DW;
`ifdef ZETA_GEN_MONT_EN
  localparam int unsigned R_MOD = (32'd1 << MONT_BITS) % Q;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
`ifdef ZETA_GEN_MONT_EN
    S_CONV,
`endif
    S_EMIT,
    S_MUL,
    S_RED
  } state_t;

  state_t          state_q;
  logic [N-1:0]    j_q;
  logic [DW-1:0]   p_q;
  logic [PW-1:0]   prod_q;
  logic            busy_q;
  logic            done_q;
  logic            wr_valid_q;
  logic [SW-1:0]   wr_stage_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;

  logic [N-1:0]    k_d;
  logic [SW-1:0]   stage_d;
  logic [N-1:0]    base_d;
  logic [AW-1:0]   addr_d;

  // k is the bit-reversal of the exponent counter j
  always_comb begin
    k_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k_d[i] = j_q[N-1-i];
    end
  end

  // Bank index is the position of the leading one of k
  always_comb begin
    stage_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_d[i]) begin
        stage_d = SW'(i);
      end
    end
  end

  always_comb begin
    base_d = N'(1) << stage_d;
    addr_d = AW'(k_d - base_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      p_q        <= DW'(1);
      prod_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_stage_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped
          if (start && !done_q) begin
            busy_q  <= 1'b1;
            state_q <= S_CHK;
          end
        end
        S_CHK: begin
          if (k_d == '0) begin
            state_q <= S_MUL;
          end else begin
            wr_stage_q <= stage_d;
            wr_addr_q  <= addr_d;
`ifdef ZETA_GEN_MONT_EN
            state_q    <= S_CONV;
`else
            wr_data_q  <= p_q;
            wr_valid_q <= 1'b1;
            state_q    <= S_EMIT;
`endif
          end
        end
`ifdef ZETA_GEN_MONT_EN
        S_CONV: begin
          wr_data_q  <= DW'((PW'(p_q) * PW'(R_MOD)) % PW'(Q));
          wr_valid_q <= 1'b1;
          state_q    <= S_EMIT;
        end
`endif
        S_EMIT: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            if (j_q == '1) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              j_q     <= '0;
              p_q     <= DW'(1);
              state_q <= S_IDLE;
            end else begin
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          prod_q  <= PW'(p_q) * PW'(ROOT);
          state_q <= S_RED;
        end
        S_RED: begin
          p_q     <= DW'(prod_q % PW'(Q));
          j_q     <= j_q + N'(1);
          state_q <= S_CHK;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_valid = wr_valid_q;
  assign wr_stage = wr_stage_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_zeta_gen.sv
// Self-checking bench for zeta_gen (Kyber configuration); scoreboard of expected beats in j order.
`timescale 1ns/1ps

module tb_zeta_gen;

  localparam int unsigned QV   = 3329;
  localparam int unsigned RV   = 17;
  localparam int unsigned NB   = 127;
`ifdef ZETA_GEN_MONT_EN
  localparam int unsigned SPACING = 5;
  localparam int unsigned BUSY_CYC = 636;
`else
  localparam int unsigned SPACING = 4;
  localparam int unsigned BUSY_CYC = 509;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_stage;
  logic [5:0]  wr_addr;
  logic [11:0] wr_data;

  always #5 clk = ~clk;

  zeta_gen #(.Q(3329), .ROOT(17), .MONT_BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_stage (wr_stage),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [20:0]  exp_q[$];
  logic [11:0]  bank[7][64];
  int unsigned  hits[7][64];
  int unsigned  ztab[128];
  logic [20:0]  first_beat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned brv7(input int unsigned v);
    int unsigned r = 0;
    for (int i = 0; i < 7; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic int unsigned modpow(input int unsigned b, input int unsigned e);
    int unsigned r = 1;
    for (int i = 0; i < int'(e); i++) r = (r * b) % QV;
    return r;
  endfunction

  function automatic int unsigned to_wire(input int unsigned z);
`ifdef ZETA_GEN_MONT_EN
    return (z * ((32'd1 << 16) % QV)) % QV;
`else
    return z;
`endif
  endfunction

  function automatic int unsigned msb(input int unsigned k);
    int unsigned s = 0;
    for (int i = 0; i < 7; i++) if ((k >> i) & 1) s = i;
    return s;
  endfunction

  task automatic load_expected();
    int unsigned k, s;
    logic [2:0]  st;
    logic [5:0]  ad;
    logic [11:0] dt;
    exp_q.delete();
    for (int j = 1; j <= int'(NB); j++) begin
      k  = brv7(j);
      s  = msb(k);
      st = 3'(s);
      ad = 6'(k - (1 << s));
      dt = 12'(to_wire(ztab[k]));
      exp_q.push_back({st, ad, dt});
    end
    for (int s2 = 0; s2 < 7; s2++)
      for (int a = 0; a < 64; a++) begin
        hits[s2][a] = 0;
        bank[s2][a] = '0;
      end
  endtask

  task automatic check_banks(input string tag);
    int unsigned bad = 0;
    for (int s = 0; s < 7; s++)
      for (int a = 0; a < 64; a++)
        if (a < (1 << s)) begin
          if (hits[s][a] != 1) bad++;
        end else if (hits[s][a] != 0) bad++;
    chk({tag, "_bank_hits"}, bad, 0);
    chk({tag, "_s0a0"}, 32'(bank[0][0]), to_wire(1729));
    chk({tag, "_s1a0"}, 32'(bank[1][0]), to_wire(2580));
    chk({tag, "_s1a1"}, 32'(bank[1][1]), to_wire(3289));
    chk({tag, "_s6a0"}, 32'(bank[6][0]), to_wire(17));
`ifdef ZETA_GEN_MONT_EN
    chk({tag, "_mont_s0a0"}, 32'(bank[0][0]), 2571);
    chk({tag, "_mont_s6a0"}, 32'(bank[6][0]), (17 * 2285) % 3329);
`endif
  endtask

  // One generation run. low_pct: percentage of cycles with wr_ready low;
  // poke: random start pulses while busy and in the done cycle; abort_at: beat after which rst_n pulses (0 = none).
  task automatic run_seq(input string tag, input int unsigned low_pct, input bit poke,
                         input int unsigned abort_at);
    int unsigned cyc = 0, beats = 0, busy_cnt = 0, last_hs = 0, done_cnt = 0;
    bit          stalled = 0, finished = 0, aborted = 0;
    logic [20:0] held = '0, got, expv;
    load_expected();
    @(negedge clk);
    start    = 1'b1;
    wr_ready = 1'b1;
    while (!finished && !aborted && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (stalled) chk({tag, "_stall_stable"}, 32'({wr_stage, wr_addr, wr_data}), 32'(held));
      if (done) begin
        done_cnt++;
        finished = 1;
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_beats"}, beats, NB);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        if (low_pct == 0) chk({tag, "_busy_cycles"}, busy_cnt, BUSY_CYC);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done), 0);
        repeat (3) @(negedge clk);
        chk({tag, "_idle_after"}, 32'({busy, wr_valid}), 0);
        check_banks(tag);
      end else begin
        if (poke && busy && $urandom_range(0, 7) == 0) start = 1'b1;
        wr_ready = ($urandom_range(0, 99) >= low_pct);
        if (wr_valid && wr_ready) begin
          got = {wr_stage, wr_addr, wr_data};
          beats++;
          if (exp_q.size() == 0) begin
            chk({tag, "_extra_beat"}, beats, NB);
          end else begin
            expv = exp_q.pop_front();
            chk({tag, "_beat"}, 32'(got), 32'(expv));
          end
          if (beats == 1) first_beat = got;
          chk({tag, "_data_lt_q"}, 32'(wr_data < 12'(QV)), 1);
          if (low_pct == 0 && beats > 1) chk({tag, "_spacing"}, cyc - last_hs, SPACING);
          last_hs = cyc;
          hits[wr_stage][wr_addr]++;
          bank[wr_stage][wr_addr] = wr_data;
          if (beats == abort_at) begin
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1 chk({tag, "_abort_outputs"},
                   32'({busy, done, wr_valid, wr_stage, wr_addr, wr_data}), 0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            wr_ready = 1'b1;
            aborted = 1;
          end
        end
        stalled = wr_valid && !wr_ready;
        held    = {wr_stage, wr_addr, wr_data};
      end
    end
    if (abort_at == 0) chk({tag, "_completed"}, 32'(finished), 1);
    else chk({tag, "_aborted"}, 32'(aborted), 1);
    if (abort_at == 0) chk({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) ztab[k] = modpow(RV, brv7(k));
    rst_n    = 1'b0;
    start    = 1'b0;
    wr_ready = 1'b0;
    #2;
    chk("reset_outputs", 32'({busy, done, wr_valid, wr_stage, wr_addr, wr_data}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 32'({busy, wr_valid}), 0);

    run_seq("run_ready", 0, 0, 0);
    chk("first_beat", 32'(first_beat), 32'({3'd6, 6'd0, 12'(to_wire(17))}));

    run_seq("run_bp", 30, 1, 0);

    run_seq("run_abort", 0, 0, 40);
    repeat (2) @(negedge clk);
    chk("post_abort_idle", 32'({busy, done, wr_valid}), 0);

    first_beat = '0;
    run_seq("run_restart", 0, 0, 0);
    chk("restart_first_beat", 32'(first_beat), 32'({3'd6, 6'd0, 12'(to_wire(17))}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeta_gen.md
Name: zeta_gen

Overview:
Runtime twiddle-factor generator; the write-side counterpart of the per-stage zeta ROM banks.
- Computes zeta[k] = ROOT^brv(k) mod Q for k = 1..(1<<`NTT_STAGE_CNT)-1, where brv is a `NTT_STAGE_CNT-bit reversal.
- Streams each value out with its target stage bank and in-bank address over a valid/ready write port.
- Lets the NTT stage banks be RAMs loaded after reset, so Q/ROOT changes need no .mem regeneration.

Parameters:
Q, 3329, prime modulus; must be < 2**`DATA_WIDTH.
ROOT, 17, primitive 2*(1<<`NTT_STAGE_CNT)-th root of unity mod Q.
MONT_BITS, 16, Montgomery exponent; used only with the optional feature.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin generation; sampled only in IDLE.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse after the last write is accepted.
wr_valid  out  1  write beat valid.
wr_ready  in  1  sink accepts the beat when wr_valid && wr_ready.
wr_stage  out  $clog2(`NTT_STAGE_CNT)  target bank s = floor(log2 k).
wr_addr  out  `NTT_STAGE_CNT-1  in-bank address k - (1<<s).
wr_data  out  `DATA_WIDTH  zeta value, always in [0, Q).

Behaviour:
- Reset (async assert, sync release) values: busy=0, done=0, wr_valid=0, wr_stage=0, wr_addr=0, wr_data=0. Internal state: FSM=IDLE, j=0, p=1.
- State j is a `NTT_STAGE_CNT-bit exponent counter. State p holds ROOT^j mod Q. k = brv(j).
- FSM:
  - IDLE: on start, go to CHK and set busy=1. Otherwise stay.
  - CHK: if k==0 (only j=0), go to MUL with no write. Otherwise load wr_stage/wr_addr/wr_data from k and p, assert wr_valid, go to EMIT.
  - EMIT: hold wr_valid and all wr_* stable until wr_ready.
    - On handshake with j == max: drop wr_valid, pulse done, clear busy, reset j=0 and p=1, go to IDLE.
    - On handshake otherwise: drop wr_valid, go to MUL.
  - MUL: register prod = p*ROOT (2*`DATA_WIDTH bits, no truncation). Go to RED.
  - RED: p <= prod % Q, j <= j+1, go to CHK.
- Throughput with wr_ready tied high: 4 cycles per zeta. Exactly (1<<`NTT_STAGE_CNT)-1 handshakes per run.
- Emission order is by increasing j; the first write is stage `NTT_STAGE_CNT-1, addr 0, data ROOT.
- wr_valid never drops without a handshake; wr_* never change while wr_valid && !wr_ready.
- start while busy is ignored. start in the cycle done pulses is also ignored; start is accepted again the next cycle.
- rst_n asserted mid-run aborts immediately to reset values. Partially written banks are not cleaned up; the sink must reload.
- Every generated zeta is written exactly once; k=0 is never emitted.

Optional Feature:
Macro ZETA_GEN_MONT_EN.
- Defined: adds state CONV between CHK and EMIT for k != 0. CONV registers wr_data = (p * ((1<<MONT_BITS) % Q)) % Q, i.e. the zeta in Montgomery domain. Costs +1 cycle per write (5 cycles/zeta). p itself stays in the normal domain.
- Undefined: no CONV state; wr_data = p.

Test Plan:
- Kyber config (`NTT_STAGE_CNT=7, `DATA_WIDTH=12, Q=3329, ROOT=17), wr_ready=1, pulse start -> 127 beats. Must include (stage0, addr0, 1729), (stage1, addr0, 2580), (stage1, addr1, 3289), and first beat (stage6, addr0, 17). done pulses once. busy is high 4*128-ish cycles, then 0.
- Scoreboard: collect all beats into bank arrays -> each (stage, addr) hit exactly once. Contents equal the reference Kyber zeta table indexed k=1..127. All data < 3329.
- Random wr_ready backpressure (~30% low) -> identical beat set and order. wr_* stable while stalled. No beat lost or duplicated.
- start pulses at random points during busy, and in the done cycle -> no effect. A second start after done -> identical 127-beat sequence.
- rst_n low for 1 cycle after the 40th handshake -> all outputs 0 immediately. A new start restarts from beat (6, 0, 17).
- ZETA_GEN_MONT_EN defined -> beat (stage0, addr0) carries 2571 (= -758 mod 3329) and stage6 addr0 carries 17*2285 % 3329. Handshake spacing is 5 cycles with wr_ready=1.
